// File: rtl/seg_pkg.sv
// Shared constants, scan-state type and leading-zero helper for the
// four-digit seven-segment scanner.
package seg_pkg;

   localparam int         NUM_DIGITS = 4;
   localparam logic [6:0] SEG_OFF    = 7'b1111111;
   localparam logic [3:0] AN_OFF     = 4'b1111;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_e;

   // A digit above position 0 goes dark when it and every digit to its left are zero.
   function automatic logic lz_suppressed(input logic [15:0] digits,
                                          input logic        lz,
                                          input logic [1:0]  idx);
      logic all_zero;
      all_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         if ((k >= int'(idx)) && (digits[k*4 +: 4] != 4'd0)) begin
            all_zero = 1'b0;
         end else begin
            all_zero = all_zero;
         end
      end
      return lz && (idx != 2'd0) && all_zero;
   endfunction

endpackage

// File: rtl/sevensegdecoder.sv
// BCD to active-low seven-segment decoder, bit 0 = segment a .. bit 6 = g.
// Codes 10-15 light every segment.
module sevensegdecoder (
   input  logic [3:0] num,
   output logic [6:0] seg
);

   // Combinational glyph lookup.
   always_comb begin
      case (num)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'b0000000;
      endcase
   end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode display with a blank
// gap before each digit and a once-per-frame snapshot of the inputs.
module seg_display_scanner
   import seg_pkg::*;
#(
   parameter int TICKS_PER_DIGIT = 100000,
   parameter int BLANK_TICKS     = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_mask,
   input  logic        lz_en,
   input  logic        disp_en,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame_tick
);

   localparam int            CW         = $clog2(TICKS_PER_DIGIT);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
   localparam logic [CW-1:0] DRIVE_LAST = CW'(TICKS_PER_DIGIT - BLANK_TICKS - 1);

   scan_state_e   state_r, state_s;
   logic [1:0]    idx_r, idx_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic          first_r;
   logic          frame_start_s;

   logic [15:0]   digits_snap_r;
   logic [3:0]    dp_mask_snap_r;
   logic          lz_en_snap_r;
   logic          disp_en_snap_r;

   logic [3:0]    nibble_s;
   logic [6:0]    dec_seg_s;
   logic          lit_s;
   logic [3:0]    an_s;
   logic [6:0]    seg_s;
   logic          dp_s;

   // Next scan position; the first edge after reset re-enters slot 0 as a frame start.
   always_comb begin
      state_s       = state_r;
      idx_s         = idx_r;
      cnt_s         = cnt_r + CW'(1);
      frame_start_s = 1'b0;
      if (first_r) begin
         state_s       = BLANK;
         idx_s         = 2'd0;
         cnt_s         = '0;
         frame_start_s = 1'b1;
      end else begin
         case (state_r)
            BLANK: begin
               if (cnt_r == BLANK_LAST) begin
                  state_s = DRIVE;
                  cnt_s   = '0;
               end else begin
                  state_s = BLANK;
               end
            end
            DRIVE: begin
               if (cnt_r == DRIVE_LAST) begin
                  state_s       = BLANK;
                  idx_s         = idx_r + 2'd1;
                  cnt_s         = '0;
                  frame_start_s = (idx_r == 2'd3);
               end else begin
                  state_s = DRIVE;
               end
            end
            default: begin
               state_s = BLANK;
               idx_s   = 2'd0;
               cnt_s   = '0;
            end
         endcase
      end
   end

   // Pin values for the upcoming cycle, so pins move on the same edge as the FSM.
   always_comb begin
      nibble_s = digits_snap_r[{idx_s, 2'b00} +: 4];
      lit_s    = (state_s == DRIVE) && disp_en_snap_r &&
                 !lz_suppressed(digits_snap_r, lz_en_snap_r, idx_s);
      if (lit_s) begin
         an_s  = ~(4'b0001 << idx_s);
         seg_s = dec_seg_s;
         dp_s  = ~dp_mask_snap_r[idx_s];
      end else begin
         an_s  = AN_OFF;
         seg_s = SEG_OFF;
         dp_s  = 1'b1;
      end
   end

   sevensegdecoder u_dec (
      .num (nibble_s),
      .seg (dec_seg_s)
   );

   // Scan state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= BLANK;
         idx_r   <= 2'd0;
         cnt_r   <= '0;
         first_r <= 1'b1;
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         cnt_r   <= cnt_s;
         first_r <= 1'b0;
      end
   end

   // Input snapshot, refreshed only at frame start so a frame never mixes values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits_snap_r  <= 16'h0000;
         dp_mask_snap_r <= 4'b0000;
         lz_en_snap_r   <= 1'b0;
         disp_en_snap_r <= 1'b0;
      end else if (frame_start_s) begin
         digits_snap_r  <= digits;
         dp_mask_snap_r <= dp_mask;
         lz_en_snap_r   <= lz_en;
         disp_en_snap_r <= disp_en;
      end
   end

   // Registered board pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an         <= AN_OFF;
         seg        <= SEG_OFF;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         an         <= an_s;
         seg        <= seg_s;
         dp         <= dp_s;
         frame_tick <= frame_start_s;
      end
   end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner: directed frame table, mid-frame
// and reset sequences, and random frames against a frame-time reference model.
module tb_seg_display_scanner;

   localparam int TPD   = 8;
   localparam int BT    = 2;
   localparam int FRAME = 4 * TPD;

   localparam logic [6:0] S0  = 7'b1000000;
   localparam logic [6:0] S1  = 7'b1111001;
   localparam logic [6:0] S2  = 7'b0100100;
   localparam logic [6:0] S3  = 7'b0110000;
   localparam logic [6:0] S4  = 7'b0011001;
   localparam logic [6:0] S5  = 7'b0010010;
   localparam logic [6:0] S6  = 7'b0000010;
   localparam logic [6:0] S7  = 7'b1111000;
   localparam logic [6:0] S8  = 7'b0000000;
   localparam logic [6:0] S9  = 7'b0010000;
   localparam logic [6:0] OFF = 7'b1111111;
   localparam logic [6:0] ALL = 7'b0000000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] digits;
   logic [3:0]  dp_mask;
   logic        lz_en;
   logic        disp_en;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [15:0] digits;
      logic [3:0]  dp_mask;
      logic        lz_en;
      logic        disp_en;
      logic [15:0] an_all;
      logic [27:0] seg_all;
      logic [3:0]  dp_n;
   } vec_t;

   vec_t       vecs [8];
   logic [6:0] shape [16];

   int          t;
   bit          started;
   logic [15:0] m_digits;
   logic [3:0]  m_dp;
   logic        m_lz;
   logic        m_en;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_dp;
   logic        exp_ft;

   seg_display_scanner #(
      .TICKS_PER_DIGIT (TPD),
      .BLANK_TICKS     (BT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .digits     (digits),
      .dp_mask    (dp_mask),
      .lz_en      (lz_en),
      .disp_en    (disp_en),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (frame time %0d)", name, act, exp, t);
      end
   endtask

   function automatic bit blanked_lead(input logic [15:0] d, input logic lz, input int k);
      if (!lz || k == 0) return 1'b0;
      for (int j = k; j < 4; j++) begin
         if (d[j*4 +: 4] != 4'd0) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Reference: position in the frame decides everything; slot = t/TPD, blank gap first.
   task automatic model_outputs();
      int slot;
      int pos;
      slot   = t / TPD;
      pos    = t % TPD;
      exp_ft = (t == 0);
      exp_an = 4'b1111;
      if (pos >= BT && m_en && !blanked_lead(m_digits, m_lz, slot)) begin
         exp_an[slot] = 1'b0;
         exp_seg      = shape[m_digits[slot*4 +: 4]];
         exp_dp       = !m_dp[slot];
      end else begin
         exp_seg = OFF;
         exp_dp  = 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (!started) begin
         t       = 0;
         started = 1'b1;
      end else begin
         t = (t + 1) % FRAME;
      end
      if (t == 0) begin
         m_digits = digits;
         m_dp     = dp_mask;
         m_lz     = lz_en;
         m_en     = disp_en;
      end
      model_outputs();
      chk("an", {28'd0, an}, {28'd0, exp_an});
      chk("seg", {25'd0, seg}, {25'd0, exp_seg});
      chk("dp", {31'd0, dp}, {31'd0, exp_dp});
      chk("frame_tick", {31'd0, frame_tick}, {31'd0, exp_ft});
   endtask

   task automatic set_inputs(input logic [15:0] d, input logic [3:0] m, input logic lz, input logic en);
      digits  = d;
      dp_mask = m;
      lz_en   = lz;
      disp_en = en;
   endtask

   initial begin
      shape[0]  = S0; shape[1]  = S1; shape[2]  = S2; shape[3]  = S3;
      shape[4]  = S4; shape[5]  = S5; shape[6]  = S6; shape[7]  = S7;
      shape[8]  = S8; shape[9]  = S9;
      for (int i = 10; i < 16; i++) shape[i] = ALL;

      vecs[0] = '{16'h1234, 4'b0000, 1'b0, 1'b1, 16'b0111_1011_1101_1110, {S1, S2, S3, S4}, 4'b1111};
      vecs[1] = '{16'h0050, 4'b0000, 1'b1, 1'b1, 16'b1111_1111_1101_1110, {OFF, OFF, S5, S0}, 4'b1111};
      vecs[2] = '{16'h0000, 4'b0000, 1'b1, 1'b1, 16'b1111_1111_1111_1110, {OFF, OFF, OFF, S0}, 4'b1111};
      vecs[3] = '{16'h1111, 4'b0100, 1'b0, 1'b1, 16'b0111_1011_1101_1110, {S1, S1, S1, S1}, 4'b1011};
      vecs[4] = '{16'h8888, 4'b1111, 1'b0, 1'b0, 16'b1111_1111_1111_1111, {OFF, OFF, OFF, OFF}, 4'b1111};
      vecs[5] = '{16'h00AF, 4'b0011, 1'b1, 1'b1, 16'b1111_1111_1101_1110, {OFF, OFF, ALL, ALL}, 4'b1100};
      vecs[6] = '{16'h0900, 4'b1000, 1'b1, 1'b1, 16'b1111_1011_1101_1110, {OFF, S9, S0, S0}, 4'b1111};
      vecs[7] = '{16'h7600, 4'b0000, 1'b1, 1'b1, 16'b0111_1011_1101_1110, {S7, S6, S0, S0}, 4'b1111};

      started = 1'b0;
      t       = 0;
      rst_n   = 1'b0;
      set_inputs(16'h1234, 4'b0000, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_an", {28'd0, an}, 32'hF);
      chk("reset_seg", {25'd0, seg}, 32'h7F);
      chk("reset_dp", {31'd0, dp}, 32'd1);
      chk("reset_frame_tick", {31'd0, frame_tick}, 32'd0);

      // Directed frames, one table row per frame.
      @(negedge clk);
      set_inputs(vecs[0].digits, vecs[0].dp_mask, vecs[0].lz_en, vecs[0].disp_en);
      rst_n = 1'b1;
      for (int e = 0; e < 8; e++) begin
         if (e > 0) set_inputs(vecs[e].digits, vecs[e].dp_mask, vecs[e].lz_en, vecs[e].disp_en);
         for (int c = 0; c < FRAME; c++) begin
            step();
            if (t % TPD == 4) begin
               chk("tbl_an", {28'd0, an}, {28'd0, vecs[e].an_all[(t/TPD)*4 +: 4]});
               chk("tbl_seg", {25'd0, seg}, {25'd0, vecs[e].seg_all[(t/TPD)*7 +: 7]});
               chk("tbl_dp", {31'd0, dp}, {31'd0, vecs[e].dp_n[t/TPD]});
            end
         end
      end

      // Mid-frame input change stays invisible until the next frame.
      set_inputs(16'h1111, 4'b0000, 1'b0, 1'b1);
      repeat (12) step();
      digits = 16'h2222;
      for (int c = 12; c < FRAME; c++) begin
         step();
         if (t == 20) chk("midframe_old", {25'd0, seg}, {25'd0, S1});
      end
      for (int c = 0; c < FRAME; c++) begin
         step();
         if (t == 20) chk("midframe_new", {25'd0, seg}, {25'd0, S2});
      end

      // Random frames with inputs wiggling at arbitrary cycles.
      for (int f = 0; f < 24; f++) begin
         for (int c = 0; c < FRAME; c++) begin
            if (c == 0 || $urandom_range(0, 7) == 0) begin
               for (int n = 0; n < 4; n++) begin
                  digits[n*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
               end
               dp_mask = 4'($urandom_range(0, 15));
               lz_en   = 1'($urandom_range(0, 1));
               disp_en = ($urandom_range(0, 5) != 0);
            end
            step();
         end
      end

      // Reset in the middle of a DRIVE slot, then a clean restart at digit 0.
      set_inputs(16'h1234, 4'b0010, 1'b0, 1'b1);
      repeat (14) step();
      chk("pre_reset_an", {28'd0, an}, 32'hD);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_an", {28'd0, an}, 32'hF);
      chk("async_seg", {25'd0, seg}, 32'h7F);
      chk("async_dp", {31'd0, dp}, 32'd1);
      set_inputs(16'h5678, 4'b0001, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      started = 1'b0;
      for (int c = 0; c < FRAME; c++) begin
         step();
         if (t == 0) chk("restart_tick", {31'd0, frame_tick}, 32'd1);
         if (t == 4) begin
            chk("restart_an", {28'd0, an}, 32'hE);
            chk("restart_seg", {25'd0, seg}, {25'd0, S8});
            chk("restart_dp", {31'd0, dp}, 32'd0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
